nfi_scheduler: RTL and testbench

Parametrised successor to the next-field-iteration (NFI) controller. It schedules Game of Life generation steps by issuing a single-cycle o_go to the field-iteration engine, then waits for that engine's completion handshake. It adds selectable speed, run/pause/single-step modes, a go/done handshake and a generation counter. It sits between the user-control logic (buttons/switches) and the next-field-iteration engine.

---
 rtl/nfi_scheduler.sv | 131 +++++++++++++
 tb/tb_nfi_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfi_scheduler.sv
// -----------------------------------------------------------------------------
// nfi_scheduler
//
// Paces Game of Life generation steps. In run mode it counts enabled cycles
// up to a speed-dependent period. In single-step mode it waits for a step
// request. Either way it then fires a one-cycle start pulse at the
// field-iteration engine and waits for that engine's completion pulse. It
// also counts completed generations.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   i_NFI_allowed iteration permitted; gates counting and stepping
//   i_mode        00 pause, 01 run, 10 single-step, 11 pause
//   i_step        single-cycle step request (single-step mode only)
//   i_speed       speed select; period = BASE_CNT << i_speed
//   i_done        single-cycle completion pulse from the iteration engine
//   o_go          single-cycle start pulse to the iteration engine
//   o_busy        high from the o_go cycle until i_done is accepted
//   o_gen_cnt     completed generations, wraps modulo 2**GEN_W
// -----------------------------------------------------------------------------
module nfi_scheduler #(
  parameter int unsigned BASE_CNT = 10,
  parameter int unsigned SPEED_W  = 2,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned GEN_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_NFI_allowed,
  input  logic [1:0]         i_mode,
  input  logic               i_step,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic               i_done,
  output logic               o_go,
  output logic               o_busy,
  output logic [GEN_W-1:0]   o_gen_cnt
);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_GO,
    ST_BUSY
  } state_t;

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  // One extra bit so the largest shifted period cannot overflow.
  localparam logic [CNT_W:0] BASE_PERIOD = (CNT_W+1)'(BASE_CNT);

  state_t           state_q;
  logic [CNT_W-1:0] delayCnt_q;
  logic [CNT_W:0]   period;
  logic [CNT_W:0]   lastCount;
  logic             countDone;

  // The test is >= rather than ==. If the speed is lowered while counting,
  // the counter may already be past the new limit, and it must fire
  // instead of wrapping around.
  assign period    = BASE_PERIOD << i_speed;
  assign lastCount = period - (CNT_W+1)'(1);
  assign countDone = {1'b0, delayCnt_q} >= lastCount;

  // State, delay counter and all outputs live in one register block.
  // o_go and o_busy are loaded together with the state they belong to, so
  // they line up with that state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_WAIT;
      delayCnt_q <= '0;
      o_go       <= 1'b0;
      o_busy     <= 1'b0;
      o_gen_cnt  <= '0;
    end else begin
      o_go <= 1'b0;
      case (state_q)
        ST_WAIT: begin
          o_busy <= 1'b0;
          case (i_mode)
            MODE_RUN: begin
              if (i_NFI_allowed) begin
                if (countDone) begin
                  delayCnt_q <= '0;
                  state_q    <= ST_GO;
                  o_go       <= 1'b1;
                  o_busy     <= 1'b1;
                end else begin
                  delayCnt_q <= delayCnt_q + 1'b1;
                end
              end
            end
            MODE_STEP: begin
              // A step that arrives while stepping is not allowed is dropped, not queued.
              delayCnt_q <= '0;
              if (i_step && i_NFI_allowed) begin
                state_q <= ST_GO;
                o_go    <= 1'b1;
                o_busy  <= 1'b1;
              end
            end
            default: begin
              // Pause, and the unused mode 11, throw away count progress.
              delayCnt_q <= '0;
            end
          endcase
        end
        ST_GO: begin
          // A done pulse in the GO cycle cannot be a reply to this go, so it is ignored.
          state_q <= ST_BUSY;
          o_busy  <= 1'b1;
        end
        ST_BUSY: begin
          o_busy <= 1'b1;
          if (i_done) begin
            state_q    <= ST_WAIT;
            o_busy     <= 1'b0;
            delayCnt_q <= '0;
            o_gen_cnt  <= o_gen_cnt + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_WAIT;
          o_busy     <= 1'b0;
          delayCnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nfi_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nfi_scheduler
//
// Directed bench for nfi_scheduler. The DUT is built with GEN_W=4 so that
// generation-counter wraparound shows up within a short run. Every input
// changes 1 time unit after a rising edge. Every output is sampled at that
// same point, so an observation describes the cycle that has just started.
// -----------------------------------------------------------------------------
module tb_nfi_scheduler;

  localparam int BASE_CNT = 10;
  localparam int SPEED_W  = 2;
  localparam int CNT_W    = 16;
  localparam int GEN_W    = 4;
  localparam int GEN_MOD  = 1 << GEN_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               allowed;
  logic [1:0]         mode;
  logic               step;
  logic [SPEED_W-1:0] speed;
  logic               done;
  logic               go;
  logic               busy;
  logic [GEN_W-1:0]   genCnt;

  int assertCount = 0;
  int failCount   = 0;
  int expGen;
  int n;
  int gos;
  int highCnt;
  int runLeft;
  int cycles;
  logic prevBusy;
  bit   found;

  nfi_scheduler #(
    .BASE_CNT(BASE_CNT),
    .SPEED_W (SPEED_W),
    .CNT_W   (CNT_W),
    .GEN_W   (GEN_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_NFI_allowed(allowed),
    .i_mode       (mode),
    .i_step       (step),
    .i_speed      (speed),
    .i_done       (done),
    .o_go         (go),
    .o_busy       (busy),
    .o_gen_cnt    (genCnt)
  );

  always #5 clk = ~clk;

  // Stop a hung run without losing the report.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive the static control inputs.
  task automatic applyStimulus(input logic [1:0] m, input logic a,
                               input logic [SPEED_W-1:0] s);
    mode    = m;
    allowed = a;
    speed   = s;
  endtask

  // Advance one cycle and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count the cycles until o_go is seen. The result is -1 if o_go does not
  // appear within the limit.
  task automatic waitGo(input int limit, output int cnt);
    cnt = 0;
    while (go !== 1'b1 && cnt < limit) begin
      tick();
      cnt++;
    end
    if (go !== 1'b1) cnt = -1;
  endtask

  // Start in the GO cycle. Raise i_done for one cycle, 'delay' cycles after
  // o_go. Return in the first WAIT cycle.
  task automatic finishGen(input int delay);
    repeat (delay) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    expGen = (expGen + 1) % GEN_MOD;
  endtask

  // Count the o_go pulses seen over a fixed number of cycles.
  task automatic countGo(input int numCycles, output int cnt);
    cnt = 0;
    repeat (numCycles) begin
      tick();
      if (go === 1'b1) cnt++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    step   = 1'b0;
    done   = 1'b0;
    expGen = 0;
    applyStimulus(2'b01, 1'b1, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_go", go, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_gen", genCnt, 0);
    rst_n = 1'b1;

    // Run mode at speed 0: the first go comes at cycle 10, then one every 14 cycles.
    waitGo(100, n);
    checkOutput("t1_first_go", n, 10);
    checkOutput("t1_busy_with_go", busy, 1);
    for (int g = 1; g <= 3; g++) begin
      finishGen(3);
      checkOutput("t1_gen", genCnt, expGen);
      checkOutput("t1_busy_cleared", busy, 0);
      waitGo(100, n);
      checkOutput("t1_spacing", (n < 0) ? -1 : n + 4, 14);
    end
    finishGen(3);

    // Speed 2 gives a period of 40. Dropping the speed mid-count fires on the next cycle.
    applyStimulus(2'b01, 1'b1, 2'd2);
    waitGo(200, n);
    checkOutput("t2_first_go", n, 40);
    finishGen(3);
    waitGo(200, n);
    checkOutput("t2_spacing", (n < 0) ? -1 : n + 4, 44);
    finishGen(3);
    checkOutput("t2_gen", genCnt, expGen);
    repeat (25) tick();
    checkOutput("t2_no_go_at_25", go, 0);
    speed = 2'd0;
    tick();
    checkOutput("t2_go_after_lower", go, 1);
    finishGen(3);

    // Toggle i_NFI_allowed at random: each go needs exactly 10 allowed WAIT cycles.
    for (int g = 0; g < 3; g++) begin
      highCnt  = 0;
      cycles   = 0;
      found    = 1'b0;
      prevBusy = busy;
      runLeft  = $urandom_range(1, 10);
      allowed  = 1'($urandom_range(0, 1));
      while (!found && cycles < 500) begin
        if (allowed && !busy) highCnt++;
        prevBusy = busy;
        tick();
        cycles++;
        if (go === 1'b1) begin
          found = 1'b1;
        end else begin
          runLeft--;
          if (runLeft == 0) begin
            allowed = ~allowed;
            runLeft = $urandom_range(1, 10);
          end
        end
      end
      checkOutput("t3_allowed_cycles", found ? highCnt : -1, 10);
      checkOutput("t3_go_not_while_busy", prevBusy, 0);
      tick();
      checkOutput("t3_go_single_cycle", go, 0);
      done = 1'b1;
      tick();
      done = 1'b0;
      expGen = (expGen + 1) % GEN_MOD;
      checkOutput("t3_gen", genCnt, expGen);
    end
    allowed = 1'b1;

    // Single-step, pause and mode-change behaviour.
    applyStimulus(2'b10, 1'b1, 2'd0);
    countGo(15, gos);
    checkOutput("t4_step_idle", gos, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    checkOutput("t4_step_go", go, 1);
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    expGen = (expGen + 1) % GEN_MOD;
    checkOutput("t4_step_gen", genCnt, expGen);
    countGo(10, gos);
    checkOutput("t4_step_in_busy", gos, 0);
    allowed = 1'b0;
    step    = 1'b1;
    tick();
    step    = 1'b0;
    allowed = 1'b1;
    countGo(10, gos);
    checkOutput("t4_step_not_allowed", gos, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("t4_done_in_wait", genCnt, expGen);
    applyStimulus(2'b00, 1'b1, 2'd0);
    countGo(100, gos);
    checkOutput("t4_pause", gos, 0);
    applyStimulus(2'b01, 1'b1, 2'd0);
    waitGo(100, n);
    checkOutput("t4_pause_to_run", n, 10);
    finishGen(3);
    repeat (7) tick();
    mode = 2'b11;
    tick();
    mode = 2'b01;
    waitGo(100, n);
    checkOutput("t4_pause_discards", n, 10);

    // Reset while BUSY. A late i_done after release must be ignored.
    tick();
    checkOutput("t5_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #2;
    checkOutput("t5_busy_in_reset", busy, 0);
    checkOutput("t5_gen_in_reset", genCnt, 0);
    checkOutput("t5_go_in_reset", go, 0);
    rst_n = 1'b1;
    done  = 1'b1;
    tick();
    done  = 1'b0;
    expGen = 0;
    checkOutput("t5_stray_done_gen", genCnt, 0);
    checkOutput("t5_stray_done_busy", busy, 0);

    // 17 generations with a 4-bit counter: ..., 14, 15, 0, 1.
    for (int i = 1; i <= 17; i++) begin
      waitGo(100, n);
      checkOutput("t6_go_seen", (n >= 0) ? 1 : 0, 1);
      if (n < 0) break;
      finishGen(3);
      checkOutput("t6_gen_wrap", genCnt, i % GEN_MOD);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
